// File: rtl/npu_attn_pkg.sv
// Shared types and default sizing for the attention row scheduler and its watchdog.
// Index widths are derived from the default engine geometry.
package npu_attn_pkg;

    localparam int ATT_M       = 166;
    localparam int ATT_N       = 44;
    localparam int ATT_H       = 4;
    localparam int ATT_TIMEOUT = 16384;

    localparam int ATT_ROWS_W     = $clog2(ATT_M + 1);
    localparam int ATT_HEADS_W    = $clog2(ATT_H + 1);
    localparam int ATT_ROW_IDX_W  = $clog2(ATT_M);
    localparam int ATT_HEAD_IDX_W = $clog2(ATT_H);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_WRITE,
        ST_NEXT,
        ST_FIN
    } attn_sched_state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/attn_watchdog.sv
// Cycle watchdog for the attention engine: counts enabled cycles since the last clear
// and flags expiry on the TIMEOUT-th enabled cycle.
module attn_watchdog
    import npu_attn_pkg::*;
#(
    parameter int TIMEOUT = ATT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = idx_w(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expire = enable && (count_q == LAST);

    // Saturate at LAST so a missed expiry can never wrap back to a fresh window.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expire) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/attn_row_scheduler.sv
// Walks the single-row attention engine over every (head,row) of a command, head-major,
// moving Q rows from the Q RAM into the engine and engine results into the output RAM.
module attn_row_scheduler
    import npu_attn_pkg::*;
#(
    parameter int M       = ATT_M,
    parameter int N       = ATT_N,
    parameter int H       = ATT_H,
    parameter int TIMEOUT = ATT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [$clog2(M+1)-1:0]   cmd_rows,
    input  logic [$clog2(H+1)-1:0]   cmd_heads,
    input  logic                     abort,
    output logic                     q_rd_en,
    output logic [$clog2(H)-1:0]     q_rd_head,
    output logic [$clog2(M)-1:0]     q_rd_row,
    input  logic [8*N-1:0]           q_rd_data,
    output logic [8*N-1:0]           att_q,
    output logic [$clog2(H)-1:0]     att_head,
    output logic                     att_start,
    input  logic                     att_out_valid,
    input  logic [8*N-1:0]           att_out_data,
    output logic                     out_we,
    output logic [$clog2(H)-1:0]     out_head,
    output logic [$clog2(M)-1:0]     out_row,
    output logic [8*N-1:0]           out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout
);

    localparam int RW  = $clog2(M + 1);
    localparam int HW  = $clog2(H + 1);
    localparam int RIW = $clog2(M);
    localparam int HIW = $clog2(H);
    localparam int DW  = 8 * N;

    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [HW-1:0] HEAD_ONE = HW'(1);

    attn_sched_state_t state_q, state_d;

    logic [RW-1:0] rows_q, rows_d;
    logic [HW-1:0] heads_q, heads_d;
    logic [RW-1:0] row_q, row_d;
    logic [HW-1:0] head_q, head_d;
    logic          wait_first_q, wait_first_d;
    logic [DW-1:0] att_q_q, att_q_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          q_rd_en_q, q_rd_en_d;
    logic          att_start_q, att_start_d;
    logic          out_we_q, out_we_d;
    logic          busy_q, busy_d;
    logic          cmd_ready_q, cmd_ready_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expire;

    attn_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        heads_d      = heads_q;
        row_d        = row_q;
        head_d       = head_q;
        wait_first_d = 1'b0;
        att_q_d      = att_q_q;
        out_data_d   = out_data_q;
        err_d        = err_q;
        done_d       = 1'b0;
        wd_clear     = 1'b0;
        wd_enable    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rows_d  = cmd_rows;
                    heads_d = cmd_heads;
                    row_d   = '0;
                    head_d  = '0;
                    err_d   = 1'b0;
                    state_d = (cmd_rows == '0 || cmd_heads == '0) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                att_q_d = q_rd_data;
                state_d = ST_START;
            end
            ST_START: begin
                wd_clear     = 1'b1;
                wait_first_d = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // The first WAIT cycle may still see the previous row's valid level.
                wd_enable = 1'b1;
                if (!wait_first_q && att_out_valid) begin
                    out_data_d = att_out_data;
                    state_d    = ST_WRITE;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_NEXT;
            ST_NEXT: begin
                if (row_q == rows_q - ROW_ONE) begin
                    row_d = '0;
                    if (head_q == heads_q - HEAD_ONE) begin
                        head_d  = '0;
                        state_d = ST_FIN;
                    end else begin
                        head_d  = head_q + HEAD_ONE;
                        state_d = ST_FETCH;
                    end
                end else begin
                    row_d   = row_q + ROW_ONE;
                    state_d = ST_FETCH;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // FIN is already reporting done, so an abort there must not stretch the pulse.
        if (abort && state_q != ST_IDLE && state_q != ST_FIN) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            row_d      = row_q;
            head_d     = head_q;
            att_q_d    = att_q_q;
            out_data_d = out_data_q;
            err_d      = err_q;
        end

        done_d      = done_d || (state_d == ST_FIN);
        q_rd_en_d   = (state_d == ST_FETCH);
        att_start_d = (state_d == ST_START);
        out_we_d    = (state_d == ST_WRITE);
        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rows_q       <= '0;
            heads_q      <= '0;
            row_q        <= '0;
            head_q       <= '0;
            wait_first_q <= 1'b0;
            att_q_q      <= '0;
            out_data_q   <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            q_rd_en_q    <= 1'b0;
            att_start_q  <= 1'b0;
            out_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            heads_q      <= heads_d;
            row_q        <= row_d;
            head_q       <= head_d;
            wait_first_q <= wait_first_d;
            att_q_q      <= att_q_d;
            out_data_q   <= out_data_d;
            err_q        <= err_d;
            done_q       <= done_d;
            q_rd_en_q    <= q_rd_en_d;
            att_start_q  <= att_start_d;
            out_we_q     <= out_we_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign q_rd_en     = q_rd_en_q;
    assign q_rd_head   = head_q[HIW-1:0];
    assign q_rd_row    = row_q[RIW-1:0];
    assign att_q       = att_q_q;
    assign att_head    = head_q[HIW-1:0];
    assign att_start   = att_start_q;
    assign out_we      = out_we_q;
    assign out_head    = head_q[HIW-1:0];
    assign out_row     = row_q[RIW-1:0];
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_attn_row_scheduler.sv
// Self-checking bench: Q RAM and engine responders, a head-major reference sequence,
// table-driven commands, randomized commands and hand-written abort/reset/hold sequences.
module tb_attn_row_scheduler;
    import npu_attn_pkg::*;

    localparam int M   = ATT_M;
    localparam int N   = ATT_N;
    localparam int H   = ATT_H;
    localparam int TO  = 64;
    localparam int RW  = $clog2(M + 1);
    localparam int HW  = $clog2(H + 1);
    localparam int RIW = $clog2(M);
    localparam int HIW = $clog2(H);
    localparam int DW  = 8 * N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [RW-1:0]  cmd_rows = '0;
    logic [HW-1:0]  cmd_heads = '0;
    logic           abort = 1'b0;
    logic           q_rd_en;
    logic [HIW-1:0] q_rd_head;
    logic [RIW-1:0] q_rd_row;
    logic [DW-1:0]  q_rd_data = '0;
    logic [DW-1:0]  att_q;
    logic [HIW-1:0] att_head;
    logic           att_start;
    logic           att_out_valid = 1'b0;
    logic [DW-1:0]  att_out_data = '0;
    logic           out_we;
    logic [HIW-1:0] out_head;
    logic [RIW-1:0] out_row;
    logic [DW-1:0]  out_data;
    logic           busy;
    logic           done;
    logic           err_timeout;

    attn_row_scheduler #(.M(M), .N(N), .H(H), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rows(cmd_rows), .cmd_heads(cmd_heads), .abort(abort),
        .q_rd_en(q_rd_en), .q_rd_head(q_rd_head), .q_rd_row(q_rd_row), .q_rd_data(q_rd_data),
        .att_q(att_q), .att_head(att_head), .att_start(att_start),
        .att_out_valid(att_out_valid), .att_out_data(att_out_data),
        .out_we(out_we), .out_head(out_head), .out_row(out_row), .out_data(out_data),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int h; int r; logic [DW-1:0] d; } wr_t;
    typedef struct { int h; logic [DW-1:0] q; } st_t;
    typedef struct { int rows; int heads; int lat; int exp_writes; int exp_err; } vec_t;

    wr_t           wr_q[$];
    st_t           st_q[$];
    logic [DW-1:0] inj_q[$];
    int done_cnt = 0, done_cyc = 0, acc_cnt = 0, acc_cyc = 0;
    int eng_lat = 0, eng_cnt = 0;
    logic q_pend = 1'b0;
    int pend_h = 0, pend_r = 0;

    function automatic logic [DW-1:0] qrow(input int h, input int r);
        logic [DW-1:0] v;
        v = '0;
        v[7:0]  = 8'(r);
        v[15:8] = 8'(h);
        for (int j = 2; j < N; j++) v[8*j +: 8] = 8'(r * 7 + h * 13 + j);
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[8*j +: 8] = 8'($urandom);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Q RAM (1-cycle read latency, garbage otherwise), engine responder and event monitor.
    always @(negedge clk) begin
        if (rst) begin
            q_pend = 1'b0;
            eng_cnt = 0;
            att_out_valid = 1'b0;
        end else begin
            q_rd_data = q_pend ? qrow(pend_h, pend_r) : rand_row();
            q_pend = q_rd_en;
            pend_h = int'(q_rd_head);
            pend_r = int'(q_rd_row);
            if (att_start) begin
                st_q.push_back('{h: int'(att_head), q: att_q});
                att_out_valid = 1'b0;
                att_out_data = rand_row();
                inj_q.push_back(att_out_data);
                eng_cnt = eng_lat;
            end else if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) att_out_valid = 1'b1;
            end
            if (out_we) wr_q.push_back('{h: int'(out_head), r: int'(out_row), d: out_data});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                acc_cnt++;
                acc_cyc = cyc;
            end
        end
    end

    task automatic clear_log();
        wr_q.delete();
        st_q.delete();
        inj_q.delete();
        done_cnt = 0;
    endtask

    // lat == 0 models an engine that never answers.
    task automatic run_cmd(input string tag, input int rows, input int heads, input int lat,
                           input int exp_writes, input int exp_err);
        int eh[$];
        int er[$];
        int n, exp_rel, n_st, n_wr, budget;
        clear_log();
        eng_lat = lat;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_rows  = RW'(rows);
        cmd_heads = HW'(heads);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk({tag, " err_cleared"}, int'(err_timeout), 0);
        chk({tag, " busy"}, int'(busy), 1);

        if (rows > 0 && heads > 0)
            for (int h = 0; h < heads; h++)
                for (int r = 0; r < rows; r++) begin
                    eh.push_back(h);
                    er.push_back(r);
                end
        n = eh.size();
        if (lat == 0 && n > 0) begin
            exp_rel = 4 + TO;
            n_st = 1;
            n_wr = 0;
        end else begin
            exp_rel = 1 + n * (lat + 5);
            n_st = n;
            n_wr = n;
        end

        budget = exp_rel + 40;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != 0) break;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);

        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_latency"}, done_cyc - acc_cyc, exp_rel);
        chk({tag, " writes"}, wr_q.size(), exp_writes);
        chk({tag, " starts"}, st_q.size(), n_st);
        chk({tag, " err_timeout"}, int'(err_timeout), exp_err);
        chk({tag, " busy_after"}, int'(busy), 0);
        for (int k = 0; k < n_st && k < st_q.size(); k++) begin
            chk({tag, " start_head"}, st_q[k].h, eh[k]);
            chk({tag, " att_q_byte0"}, int'(st_q[k].q[7:0]), er[k]);
            chk_row({tag, " att_q"}, st_q[k].q, qrow(eh[k], er[k]));
        end
        for (int k = 0; k < n_wr && k < wr_q.size(); k++) begin
            chk({tag, " write_idx"}, wr_q[k].h * 256 + wr_q[k].r, eh[k] * 256 + er[k]);
            chk_row({tag, " out_data"}, wr_q[k].d, inj_q[k]);
        end
        if (rows == M && wr_q.size() > 0)
            chk({tag, " last_row"}, wr_q[wr_q.size() - 1].r, M - 1);
    endtask

    vec_t vecs[7];
    int acc0;
    int r_rows, r_heads, r_lat;

    initial begin
        vecs[0] = '{rows: 3,   heads: 2, lat: 10, exp_writes: 6,   exp_err: 0};
        vecs[1] = '{rows: 1,   heads: 1, lat: 2,  exp_writes: 1,   exp_err: 0};
        vecs[2] = '{rows: 0,   heads: 2, lat: 5,  exp_writes: 0,   exp_err: 0};
        vecs[3] = '{rows: 2,   heads: 0, lat: 5,  exp_writes: 0,   exp_err: 0};
        vecs[4] = '{rows: 2,   heads: 1, lat: 0,  exp_writes: 0,   exp_err: 1};
        vecs[5] = '{rows: 4,   heads: 4, lat: 3,  exp_writes: 16,  exp_err: 0};
        vecs[6] = '{rows: 166, heads: 1, lat: 2,  exp_writes: 166, exp_err: 0};

        repeat (3) @(negedge clk);
        chk("reset cmd_ready", int'(cmd_ready), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset strobes", int'({q_rd_en, att_start, out_we}), 0);
        chk_row("reset att_q", att_q, '0);
        #2 rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_cmd($sformatf("vec%0d", v), vecs[v].rows, vecs[v].heads, vecs[v].lat,
                    vecs[v].exp_writes, vecs[v].exp_err);
            $display("vec%0d rows=%0d heads=%0d lat=%0d writes=%0d err=%0d", v,
                     vecs[v].rows, vecs[v].heads, vecs[v].lat, wr_q.size(), err_timeout);
            if (vecs[v].exp_err == 1) begin
                repeat (5) @(negedge clk);
                chk("err sticky", int'(err_timeout), 1);
            end
        end

        for (int t = 0; t < 6; t++) begin
            r_rows  = $urandom_range(1, 10);
            r_heads = $urandom_range(1, H);
            r_lat   = $urandom_range(2, 9);
            run_cmd($sformatf("rand%0d", t), r_rows, r_heads, r_lat, r_rows * r_heads, 0);
            $display("rand%0d rows=%0d heads=%0d lat=%0d writes=%0d", t, r_rows, r_heads, r_lat, wr_q.size());
        end

        // Abort during WAIT of h0r1.
        clear_log();
        eng_lat = 20;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rows = RW'(3); cmd_heads = HW'(2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (st_q.size() >= 2) break;
            @(negedge clk);
        end
        chk("abort reached_h0r1", st_q.size(), 2);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort done", int'(done), 1);
        chk("abort busy", int'(busy), 0);
        repeat (30) @(negedge clk);
        chk("abort starts", st_q.size(), 2);
        chk("abort writes", wr_q.size(), 1);
        chk("abort done_count", done_cnt, 1);
        $display("abort starts=%0d writes=%0d done=%0d", st_q.size(), wr_q.size(), done_cnt);
        run_cmd("post_abort", 2, 1, 4, 2, 0);

        // Asynchronous reset in WAIT.
        clear_log();
        eng_lat = 30;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rows = RW'(3); cmd_heads = HW'(1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (st_q.size() >= 2) break;
            @(negedge clk);
        end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst busy", int'(busy), 0);
        chk("rst cmd_ready", int'(cmd_ready), 1);
        chk("rst strobes", int'({q_rd_en, att_start, out_we, done, err_timeout}), 0);
        chk("rst indices", int'({att_head, q_rd_row, out_row}), 0);
        chk_row("rst att_q", att_q, '0);
        chk_row("rst out_data", out_data, '0);
        $display("reset mid-wait busy=%0d cmd_ready=%0d", busy, cmd_ready);
        @(posedge clk); #3 rst = 1'b0;

        // cmd_valid held across a command: second accept only after done.
        clear_log();
        eng_lat = 3;
        acc0 = acc_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rows = RW'(2); cmd_heads = HW'(1);
        @(posedge clk); #1 cmd_rows = RW'(7);
        for (int i = 0; i < 200; i++) begin
            if (done_cnt != 0) break;
            @(negedge clk);
        end
        chk("hold accepts_before_done", acc_cnt - acc0, 1);
        chk("hold writes_first", wr_q.size(), 2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold accepts_after_done", acc_cnt - acc0, 2);
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt >= 2) break;
            @(negedge clk);
        end
        chk("hold writes_total", wr_q.size(), 9);
        $display("hold accepts=%0d writes=%0d", acc_cnt - acc0, wr_q.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
